reg_file_mp: RTL and testbench

// - Parametrised clocked register bank for the MIPS32 datapath; successor to the single-write, combinational-write register bank.
// - Features: N read ports, one byte-enabled write port, r0 hardwired to zero, optional write-to-read bypass.
// - A per-register pending-write scoreboard lets decode stall on load-use hazards.
// - Sits between decode (read/issue) and writeback (write/retire).

---
 rtl/reg_file_mp_pkg.sv | 10 +
 rtl/reg_file_mp_if.sv | 36 +++
 rtl/reg_file_mp_rd_port.sv | 46 ++++
 rtl/reg_file_mp.sv | 77 +++++++
 tb/tb_reg_file_mp.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the MIPS32 register bank: the hardwired-zero index and
// the default geometry.
package reg_file_mp_pkg;

  localparam int REG_ZERO     = 0;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register bank: packed read ports, one
// byte-enabled write port, and the issue/retire strobes of the scoreboard.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int BE_W   = DATA_W / 8;

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [BE_W-1:0]          wr_be;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     ret_en;
    logic [ADDR_W-1:0]        ret_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_be,
               iss_en, iss_addr, ret_en, ret_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_be,
               iss_en, iss_addr, ret_en, ret_addr,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/reg_file_mp_rd_port.sv
// One combinational read port: address mux, optional same-cycle write bypass
// merged per byte, and the load-use busy term.
module reg_file_mp_rd_port
  import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                             rst_i,
    input  logic [ADDR_W-1:0]                rd_addr_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  bank_i,
    input  logic [NUM_REGS-1:0]              pend_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_W-1:0]                wr_addr_i,
    input  logic [DATA_W-1:0]                wr_data_i,
    input  logic [BE_W-1:0]                  wr_be_i,
    input  logic                             ret_en_i,
    input  logic [ADDR_W-1:0]                ret_addr_i,
    output logic [DATA_W-1:0]                rd_data_o,
    output logic                             rd_busy_o
);
    logic is_zero;
    logic wr_hit;
    logic ret_hit;

    assign is_zero = (rd_addr_i == ADDR_W'(REG_ZERO));
    assign wr_hit  = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i);
    assign ret_hit = ret_en_i && (ret_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = bank_i[rd_addr_i];
        if (wr_hit) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be_i[k]) rd_data_o[k*8 +: 8] = wr_data_i[k*8 +: 8];
            end
        end
        // Reset gates the port so an in-flight write cannot leak through the bypass.
        if (is_zero || rst_i) rd_data_o = '0;
    end

    assign rd_busy_o = pend_i[rd_addr_i] & ~ret_hit & ~rst_i;

endmodule

// File: rtl/reg_file_mp.sv
// MIPS32 register bank: NUM_RD combinational read ports, one byte-enabled
// write port, r0 hardwired to zero, and a per-register pending-write scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int BE_W    = DATA_W / 8
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);
    logic [NUM_REGS-1:0][DATA_W-1:0] bank_q, bank_d;
    logic [NUM_REGS-1:0]             pend_q, pend_d;

    logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr_w;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_w;
    logic [NUM_RD-1:0]               rd_busy_w;

    assign rd_addr_w   = bus.rd_addr;
    assign bus.rd_data = rd_data_w;
    assign bus.rd_busy = rd_busy_w;

    always_comb begin
        bank_d = bank_q;
        if (bus.wr_en && bus.wr_addr != ADDR_W'(REG_ZERO)) begin
            for (int k = 0; k < BE_W; k++) begin
                if (bus.wr_be[k]) bank_d[bus.wr_addr][k*8 +: 8] = bus.wr_data[k*8 +: 8];
            end
        end
        bank_d[REG_ZERO] = '0;
    end

    // Issue is applied after retire so a back-to-back producer keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (bus.ret_en) pend_d[bus.ret_addr] = 1'b0;
        if (bus.iss_en) pend_d[bus.iss_addr] = 1'b1;
        pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
            pend_q <= '0;
        end else begin
            bank_q <= bank_d;
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_file_mp_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .BYPASS   (BYPASS)
        ) u_rd (
            .rst_i      (rst),
            .rd_addr_i  (rd_addr_w[i]),
            .bank_i     (bank_q),
            .pend_i     (pend_q),
            .wr_en_i    (bus.wr_en),
            .wr_addr_i  (bus.wr_addr),
            .wr_data_i  (bus.wr_data),
            .wr_be_i    (bus.wr_be),
            .ret_en_i   (bus.ret_en),
            .ret_addr_i (bus.ret_addr),
            .rd_data_o  (rd_data_w[i]),
            .rd_busy_o  (rd_busy_w[i])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: a bypassing and a non-bypassing 32x32 bank driven in
// lockstep, plus a 16x64 bank with four read ports.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) ifa ();
    reg_file_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) ifb ();
    reg_file_mp_if #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) ifc ();

    // The non-bypass bank mirrors every stimulus of the bypass bank.
    assign ifb.rd_addr  = ifa.rd_addr;
    assign ifb.wr_en    = ifa.wr_en;
    assign ifb.wr_addr  = ifa.wr_addr;
    assign ifb.wr_data  = ifa.wr_data;
    assign ifb.wr_be    = ifa.wr_be;
    assign ifb.iss_en   = ifa.iss_en;
    assign ifb.iss_addr = ifa.iss_addr;
    assign ifb.ret_en   = ifa.ret_en;
    assign ifb.ret_addr = ifa.ret_addr;

    reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1))
        u_byp (.clk(clk), .rst(rst), .bus(ifa));
    reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0))
        u_nobyp (.clk(clk), .rst(rst), .bus(ifb));
    reg_file_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .BYPASS(1))
        u_wide (.clk(clk), .rst(rst), .bus(ifc));

    task automatic idle();
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.wr_be = '0;
        ifa.iss_en = 1'b0; ifa.iss_addr = '0; ifa.ret_en = 1'b0; ifa.ret_addr = '0;
        ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.wr_be = '0;
        ifc.iss_en = 1'b0; ifc.iss_addr = '0; ifc.ret_en = 1'b0; ifc.ret_addr = '0;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        ifa.wr_en = 1'b1; ifa.wr_addr = a; ifa.wr_data = d; ifa.wr_be = be;
    endtask

    task automatic test_reset();
        ifa.rd_addr = {5'd4, 5'd3};
        #3;
        total++;
        if (ifa.rd_data !== 64'h0 || ifa.rd_busy !== 2'b00) begin
            bad++; $display("FAIL reset_init: data=%h busy=%b want 0/00", ifa.rd_data, ifa.rd_busy);
        end
        @(negedge clk); rst = 1'b0;
        wr_a(5'd3, 32'h12345678, 4'hF);
        ifa.iss_en = 1'b1; ifa.iss_addr = 5'd4;
        @(posedge clk);
        @(negedge clk); idle();
        #1;
        total++;
        if (ifa.rd_data !== {32'h0, 32'h12345678} || ifa.rd_busy !== 2'b10) begin
            bad++; $display("FAIL preload: data=%h busy=%b want 0000000012345678/10", ifa.rd_data, ifa.rd_busy);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (ifa.rd_data !== 64'h0 || ifa.rd_busy !== 2'b00) begin
            bad++; $display("FAIL reset_async: data=%h busy=%b want 0/00", ifa.rd_data, ifa.rd_busy);
        end
        wr_a(5'd6, 32'hCAFEF00D, 4'hF);
        ifa.rd_addr = {5'd6, 5'd6};
        #1;
        total++;
        if (ifa.rd_data !== 64'h0) begin
            bad++; $display("FAIL reset_bypass: data=%h want 0", ifa.rd_data);
        end
        @(posedge clk);
        @(negedge clk); idle(); rst = 1'b0;
        ifa.rd_addr = {5'd6, 5'd3};
        #1;
        total++;
        if (ifa.rd_data !== 64'h0) begin
            bad++; $display("FAIL reset_after: data=%h want 0", ifa.rd_data);
        end
        ifa.rd_addr = {5'd4, 5'd4};
        #1;
        total++;
        if (ifa.rd_busy !== 2'b00) begin
            bad++; $display("FAIL reset_pend: busy=%b want 00", ifa.rd_busy);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk); wr_a(5'd5, 32'hDEADBEEF, 4'hF);
        @(negedge clk); idle(); ifa.rd_addr = {5'd0, 5'd5};
        #1;
        total++;
        if (ifa.rd_data[31:0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_full: got=%h want=deadbeef", ifa.rd_data[31:0]);
        end
        @(negedge clk); wr_a(5'd5, 32'h0000AA00, 4'b0010);
        @(negedge clk); idle();
        #1;
        total++;
        if (ifa.rd_data[31:0] !== 32'hDEADAAEF || ifb.rd_data[31:0] !== 32'hDEADAAEF) begin
            bad++; $display("FAIL wr_byte: got=%h/%h want=deadaaef", ifa.rd_data[31:0], ifb.rd_data[31:0]);
        end
    endtask

    task automatic test_r0();
        @(negedge clk); wr_a(5'd0, 32'hFFFFFFFF, 4'hF); ifa.rd_addr = {5'd0, 5'd0};
        #1;
        total++;
        if (ifa.rd_data !== 64'h0 || ifb.rd_data !== 64'h0) begin
            bad++; $display("FAIL r0_same: got=%h/%h want 0", ifa.rd_data, ifb.rd_data);
        end
        @(negedge clk); idle();
        #1;
        total++;
        if (ifa.rd_data !== 64'h0 || ifb.rd_data !== 64'h0) begin
            bad++; $display("FAIL r0_next: got=%h/%h want 0", ifa.rd_data, ifb.rd_data);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk); wr_a(5'd7, 32'h11111111, 4'hF);
        @(negedge clk); wr_a(5'd7, 32'h22222222, 4'hF); ifa.rd_addr = {5'd7, 5'd7};
        #1;
        total++;
        if (ifa.rd_data !== {2{32'h22222222}}) begin
            bad++; $display("FAIL bypass_on: got=%h want 2222222222222222", ifa.rd_data);
        end
        total++;
        if (ifb.rd_data !== {2{32'h11111111}}) begin
            bad++; $display("FAIL bypass_off: got=%h want 1111111111111111", ifb.rd_data);
        end
        @(negedge clk); wr_a(5'd7, 32'h000000FF, 4'b0001);
        #1;
        total++;
        if (ifa.rd_data[63:32] !== 32'h222222FF || ifb.rd_data[31:0] !== 32'h22222222) begin
            bad++; $display("FAIL bypass_byte: got=%h/%h want 222222ff/22222222",
                            ifa.rd_data[63:32], ifb.rd_data[31:0]);
        end
        @(negedge clk); idle();
    endtask

    task automatic test_scoreboard();
        @(negedge clk); ifa.iss_en = 1'b1; ifa.iss_addr = 5'd9; ifa.rd_addr = {5'd9, 5'd9};
        #1;
        total++;
        if (ifa.rd_busy !== 2'b00) begin
            bad++; $display("FAIL sb_iss_same: busy=%b want 00", ifa.rd_busy);
        end
        @(negedge clk); idle();
        #1;
        total++;
        if (ifa.rd_busy !== 2'b11) begin
            bad++; $display("FAIL sb_iss: busy=%b want 11", ifa.rd_busy);
        end
        @(negedge clk); ifa.iss_en = 1'b1; ifa.iss_addr = 5'd9; ifa.ret_en = 1'b1; ifa.ret_addr = 5'd9;
        @(negedge clk); idle();
        #1;
        total++;
        if (ifa.rd_busy !== 2'b11) begin
            bad++; $display("FAIL sb_set_wins: busy=%b want 11", ifa.rd_busy);
        end
        ifa.ret_en = 1'b1; ifa.ret_addr = 5'd9;
        #1;
        total++;
        if (ifa.rd_busy !== 2'b00) begin
            bad++; $display("FAIL sb_ret_same: busy=%b want 00", ifa.rd_busy);
        end
        @(negedge clk); idle();
        #1;
        total++;
        if (ifa.rd_busy !== 2'b00) begin
            bad++; $display("FAIL sb_ret: busy=%b want 00", ifa.rd_busy);
        end
        ifa.iss_en = 1'b1; ifa.iss_addr = 5'd10; ifa.ret_en = 1'b1; ifa.ret_addr = 5'd11;
        @(negedge clk); idle(); ifa.rd_addr = {5'd11, 5'd10};
        #1;
        total++;
        if (ifa.rd_busy !== 2'b01) begin
            bad++; $display("FAIL sb_other: busy=%b want 01", ifa.rd_busy);
        end
        ifa.iss_en = 1'b1; ifa.iss_addr = 5'd0;
        @(negedge clk); idle(); ifa.rd_addr = {5'd0, 5'd0};
        #1;
        total++;
        if (ifa.rd_busy !== 2'b00) begin
            bad++; $display("FAIL sb_r0: busy=%b want 00", ifa.rd_busy);
        end
    endtask

    task automatic test_params();
        logic [63:0] v [5];
        v[0] = 64'h1111111111111111; v[1] = 64'h2222222222222222;
        v[2] = 64'h3333333333333333; v[3] = 64'h4444444444444444;
        v[4] = 64'hF0F0F0F0F0F0F0F0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifc.wr_en = 1'b1; ifc.wr_addr = (i == 4) ? 4'd15 : 4'(i + 1);
            ifc.wr_data = v[i]; ifc.wr_be = 8'hFF;
        end
        @(negedge clk); idle(); ifc.rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        total++;
        if (ifc.rd_data !== {v[3], v[2], v[1], v[0]}) begin
            bad++; $display("FAIL wide_ports: got=%h", ifc.rd_data);
        end
        ifc.rd_addr = {4'd0, 4'd15, 4'd15, 4'd3};
        #1;
        total++;
        if (ifc.rd_data !== {64'h0, v[4], v[4], v[2]}) begin
            bad++; $display("FAIL wide_top: got=%h", ifc.rd_data);
        end
        ifc.wr_en = 1'b1; ifc.wr_addr = 4'd2; ifc.wr_data = 64'hAAAAAAAAAAAAAAAA; ifc.wr_be = 8'b10100101;
        @(negedge clk); idle(); ifc.rd_addr = {4'd1, 4'd1, 4'd1, 4'd2};
        #1;
        total++;
        if (ifc.rd_data[63:0] !== 64'hAA22AA2222AA22AA) begin
            bad++; $display("FAIL wide_be: got=%h want aa22aa2222aa22aa", ifc.rd_data[63:0]);
        end
    endtask

    initial begin
        ifc.rd_addr = '0;
        idle();
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_scoreboard();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
